// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display monitors:
// segment patterns {a,b,c,d,e,f,g} (bit 6 = a), special codes, FSM states.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_ERR   = 4'hE;

   typedef enum logic {
      ALIGN   = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // True when exactly one bit of an (up to) 8-bit select vector is set.
   function automatic logic onehot8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return (n == 4'd1);
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD lookup. Blank maps to CODE_BLANK
// without error; anything outside the table maps to CODE_ERR with o_err set.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_code,
   output logic       o_err
);

   // Look up the digit shown by the segment pattern
   always_comb begin
      o_code = CODE_ERR;
      o_err  = 1'b1;
      case (i_seg)
         SEG_0:     begin o_code = 4'd0;       o_err = 1'b0; end
         SEG_1:     begin o_code = 4'd1;       o_err = 1'b0; end
         SEG_2:     begin o_code = 4'd2;       o_err = 1'b0; end
         SEG_3:     begin o_code = 4'd3;       o_err = 1'b0; end
         SEG_4:     begin o_code = 4'd4;       o_err = 1'b0; end
         SEG_5:     begin o_code = 4'd5;       o_err = 1'b0; end
         SEG_6:     begin o_code = 4'd6;       o_err = 1'b0; end
         SEG_7:     begin o_code = 4'd7;       o_err = 1'b0; end
         SEG_8:     begin o_code = 4'd8;       o_err = 1'b0; end
         SEG_9:     begin o_code = 4'd9;       o_err = 1'b0; end
         SEG_BLANK: begin o_code = CODE_BLANK; o_err = 1'b0; end
         default:   begin o_code = CODE_ERR;   o_err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed 7-segment bus reader: synchronizes {dig_in, seg_in}, waits for
// a stable window, decodes the captured pattern into the digit's live slot and
// publishes a complete frame atomically once every position has been seen
// since the last digit-0 alignment.
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 8
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           seg_in,
   input  logic [NDIG-1:0]      dig_in,
   output logic [4*NDIG-1:0]    bcd_out,
   output logic [NDIG-1:0]      dig_err,
   output logic                 frame_valid,
   output logic                 frame_lost,
   output logic                 sel_err
);

   localparam int SW = NDIG + 7;
   localparam int CW = $clog2(STABLE_CYC + 1);

   logic [SW-1:0]            r_sync1;
   logic [SW-1:0]            r_sync2;
   logic [SW-1:0]            r_prev;
   logic [CW-1:0]            r_cnt;

   state_t                   r_state;
   logic [NDIG-1:0]          r_mask;
   logic [NDIG-1:0][3:0]     r_live_code;
   logic [NDIG-1:0]          r_live_err;
   logic [4*NDIG-1:0]        r_bcd;
   logic [NDIG-1:0]          r_err;
   logic                     r_fv;
   logic                     r_fl;
   logic                     r_se;

   logic [6:0]               w_seg;
   logic [NDIG-1:0]          w_dig;
   logic [3:0]               w_code;
   logic                     w_err;
   logic                     w_capture;
   logic                     w_onehot;
   logic                     w_accept;
   logic                     w_complete;
   logic [NDIG-1:0]          w_mask_next;
   logic [NDIG-1:0][3:0]     w_live_code_next;
   logic [NDIG-1:0]          w_live_err_next;

   assign w_seg = r_sync2[6:0];
   assign w_dig = r_sync2[SW-1:7];

   // Capture fires once per stable window: the counter passes STABLE_CYC-1
   // exactly once before saturating.
   assign w_capture  = (r_sync2 == r_prev) && (r_cnt == CW'(STABLE_CYC - 1));
   assign w_onehot   = onehot8(8'(w_dig));
   assign w_accept   = (r_state == COLLECT) || w_dig[0];
   assign w_complete = (w_mask_next == {NDIG{1'b1}});

   seg7_to_bcd u_dec (
      .i_seg  (w_seg),
      .o_code (w_code),
      .o_err  (w_err)
   );

   // Two-flop synchronizer, previous-sample register and saturating stability counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= {SW{1'b0}};
         r_sync2 <= {SW{1'b0}};
         r_prev  <= {SW{1'b0}};
         r_cnt   <= {CW{1'b0}};
      end else begin
         r_sync1 <= {dig_in, seg_in};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (r_sync2 != r_prev) begin
            r_cnt <= {CW{1'b0}};
         end else if (r_cnt != CW'(STABLE_CYC)) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Next mask and live slots if the current capture is accepted; a digit-0
   // capture always restarts the frame.
   always_comb begin
      w_live_code_next = r_live_code;
      w_live_err_next  = r_live_err;
      case (r_state)
         ALIGN:   w_mask_next = NDIG'(1'b1);
         COLLECT: w_mask_next = w_dig[0] ? NDIG'(1'b1) : (r_mask | w_dig);
         default: w_mask_next = NDIG'(1'b1);
      endcase
      for (int i = 0; i < NDIG; i++) begin
         if (w_dig[i]) begin
            w_live_code_next[i] = w_code;
            w_live_err_next[i]  = w_err;
         end else begin
            w_live_code_next[i] = r_live_code[i];
            w_live_err_next[i]  = r_live_err[i];
         end
      end
   end

   // Frame FSM: align on digit 0, collect positions, publish on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ALIGN;
         r_mask      <= {NDIG{1'b0}};
         r_live_code <= {(4*NDIG){1'b0}};
         r_live_err  <= {NDIG{1'b0}};
         r_bcd       <= {NDIG{CODE_BLANK}};
         r_err       <= {NDIG{1'b0}};
         r_fv        <= 1'b0;
         r_fl        <= 1'b0;
         r_se        <= 1'b0;
      end else begin
         r_fv <= 1'b0;
         r_fl <= 1'b0;
         r_se <= 1'b0;
         if (w_capture && !w_onehot) begin
            r_se <= 1'b1;
         end else if (w_capture && w_accept) begin
            r_live_code <= w_live_code_next;
            r_live_err  <= w_live_err_next;
            r_fl        <= (r_state == COLLECT) && w_dig[0] && !w_complete;
            if (w_complete) begin
               r_bcd   <= w_live_code_next;
               r_err   <= w_live_err_next;
               r_fv    <= 1'b1;
               r_mask  <= {NDIG{1'b0}};
               r_state <= ALIGN;
            end else begin
               r_mask  <= w_mask_next;
               r_state <= COLLECT;
            end
         end else begin
            r_state <= r_state;
         end
      end
   end

   assign bcd_out     = r_bcd;
   assign dig_err     = r_err;
   assign frame_valid = r_fv;
   assign frame_lost  = r_fl;
   assign sel_err     = r_se;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader. The stimulus side holds each
// {dig,seg} value for a known number of samples; any hold of STABLE_CYC+1
// or more samples is one capture, fed to a frame-level reference model that
// queues the expected pulse. A monitor pops and compares on every pulse.
module tb_seg7_scan_reader;

   localparam int NDIG       = 4;
   localparam int STABLE_CYC = 8;

   localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101,
                                       7'b1111001, 7'b0110011, 7'b1011011,
                                       7'b1011111, 7'b1110000, 7'b1111111,
                                       7'b1111011};

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [6:0]  seg_in = 7'd0;
   logic [3:0]  dig_in = 4'd0;
   logic [15:0] bcd_out;
   logic [3:0]  dig_err;
   logic        frame_valid;
   logic        frame_lost;
   logic        sel_err;

   always #5 clk = ~clk;

   seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .dig_in      (dig_in),
      .bcd_out     (bcd_out),
      .dig_err     (dig_err),
      .frame_valid (frame_valid),
      .frame_lost  (frame_lost),
      .sel_err     (sel_err)
   );

   typedef struct {
      int          kind;   // 0 frame, 1 lost, 2 select error
      logic [15:0] bcd;
      logic [3:0]  err;
   } ev_t;

   ev_t         exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] cur_bcd  = 16'hFFFF;
   logic [3:0]  cur_err  = 4'h0;

   // reference model state
   bit          m_collect = 1'b0;
   bit [3:0]    m_seen    = 4'h0;
   logic [3:0]  m_code [4];
   logic        m_err  [4];
   logic [10:0] prev_val  = 11'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void decode(input logic [6:0] s, output logic [3:0] c, output logic e);
      c = 4'hE;
      e = 1'b1;
      if (s == 7'b0000000) begin
         c = 4'hF;
         e = 1'b0;
      end
      for (int k = 0; k < 10; k++) begin
         if (PAT[k] == s) begin
            c = 4'(k);
            e = 1'b0;
         end
      end
   endfunction

   function automatic void model_capture(input logic [3:0] d, input logic [6:0] s);
      ev_t        ev;
      int         pos;
      logic [3:0] c;
      logic       e;
      ev.bcd = 16'h0;
      ev.err = 4'h0;
      if ($countones(d) != 1) begin
         ev.kind = 2;
         exp_q.push_back(ev);
         return;
      end
      pos = 0;
      for (int k = 0; k < 4; k++) if (d[k]) pos = k;
      decode(s, c, e);
      if (!m_collect) begin
         if (pos == 0) begin
            m_collect = 1'b1;
            m_seen    = 4'b0001;
            m_code[0] = c;
            m_err[0]  = e;
         end
      end else if (pos == 0) begin
         ev.kind = 1;
         exp_q.push_back(ev);
         m_seen    = 4'b0001;
         m_code[0] = c;
         m_err[0]  = e;
      end else begin
         m_code[pos]   = c;
         m_err[pos]    = e;
         m_seen[pos]   = 1'b1;
         if (m_seen == 4'hF) begin
            ev.kind = 0;
            ev.bcd  = {m_code[3], m_code[2], m_code[1], m_code[0]};
            ev.err  = {m_err[3], m_err[2], m_err[1], m_err[0]};
            exp_q.push_back(ev);
            m_collect = 1'b0;
            m_seen    = 4'h0;
         end
      end
   endfunction

   task automatic drive_item(input logic [3:0] d, input logic [6:0] s, input int h);
      @(negedge clk);
      dig_in   = d;
      seg_in   = s;
      prev_val = {d, s};
      if (h >= STABLE_CYC + 1) model_capture(d, s);
      repeat (h) @(posedge clk);
   endtask

   // Monitor: every pulse pops one expectation; outputs must hold between frames
   ev_t mon_ev;
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_valid) begin
            if (exp_q.size() == 0) chk("unexpected_frame_valid", 32'd1, 32'd0);
            else begin
               mon_ev = exp_q.pop_front();
               chk("frame_valid_kind", 32'd0, 32'(mon_ev.kind));
               cur_bcd = mon_ev.bcd;
               cur_err = mon_ev.err;
            end
         end
         if (frame_lost) begin
            if (exp_q.size() == 0) chk("unexpected_frame_lost", 32'd1, 32'd0);
            else begin
               mon_ev = exp_q.pop_front();
               chk("frame_lost_kind", 32'd1, 32'(mon_ev.kind));
            end
         end
         if (sel_err) begin
            if (exp_q.size() == 0) chk("unexpected_sel_err", 32'd1, 32'd0);
            else begin
               mon_ev = exp_q.pop_front();
               chk("sel_err_kind", 32'd2, 32'(mon_ev.kind));
            end
         end
         chk("bcd_out", 32'(bcd_out), 32'(cur_bcd));
         chk("dig_err", 32'(dig_err), 32'(cur_err));
      end
   end

   initial begin
      logic [3:0] d;
      logic [6:0] s;
      int         r;

      // reset values
      repeat (3) @(negedge clk);
      chk("reset_bcd", 32'(bcd_out), 32'h0000FFFF);
      chk("reset_err", 32'(dig_err), 32'h0);
      chk("reset_pulses", {29'd0, frame_valid, frame_lost, sel_err}, 32'h0);
      rst_n = 1'b1;

      // plain frame 0,1,2,3
      drive_item(4'b0001, PAT[0], 20);
      drive_item(4'b0010, PAT[1], 20);
      drive_item(4'b0100, PAT[2], 20);
      drive_item(4'b1000, PAT[3], 20);

      // window boundary: 7 and 8 samples too short, 9 and 10 capture
      drive_item(4'b0001, PAT[9], 7);
      drive_item(4'b0010, PAT[8], 8);
      drive_item(4'b0001, PAT[6], 10);
      drive_item(4'b0010, PAT[5], 9);

      // illegal pattern on digit 2, blank on digit 3
      drive_item(4'b0001, PAT[5], 20);
      drive_item(4'b0010, PAT[7], 20);
      drive_item(4'b0100, 7'b1010101, 20);
      drive_item(4'b1000, 7'b0000000, 20);

      // multi-hot and zero select
      drive_item(4'b0110, PAT[4], 20);
      drive_item(4'b0000, PAT[4], 20);

      // lost frame: 0,1,0,1,2,3
      drive_item(4'b0001, PAT[1], 20);
      drive_item(4'b0010, PAT[2], 20);
      drive_item(4'b0001, PAT[6], 20);
      drive_item(4'b0010, PAT[7], 20);
      drive_item(4'b0100, PAT[8], 20);
      drive_item(4'b1000, PAT[9], 20);

      // reset mid-COLLECT after digits 0,1
      drive_item(4'b0001, PAT[3], 20);
      drive_item(4'b0010, PAT[4], 20);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_bcd", 32'(bcd_out), 32'h0000FFFF);
      chk("async_reset_err", 32'(dig_err), 32'h0);
      chk("async_reset_pulses", {29'd0, frame_valid, frame_lost, sel_err}, 32'h0);
      cur_bcd   = 16'hFFFF;
      cur_err   = 4'h0;
      m_collect = 1'b0;
      m_seen    = 4'h0;
      exp_q.delete();
      dig_in = 4'b0100;
      seg_in = PAT[4];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive_item(4'b0100, PAT[4], 20);
      drive_item(4'b1000, PAT[2], 20);
      drive_item(4'b0001, PAT[8], 20);
      drive_item(4'b0010, PAT[0], 20);
      drive_item(4'b0100, PAT[1], 20);
      drive_item(4'b1000, PAT[7], 20);

      // randomized frame attempts with glitches, bad selects and bad patterns
      for (int it = 0; it < 40; it++) begin
         for (int p = 0; p < 4; p++) begin
            d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 << p);
            r = $urandom_range(0, 12);
            if (r < 10)       s = PAT[r];
            else if (r == 10) s = 7'b0000000;
            else              s = 7'($urandom_range(0, 127));
            if ({d, s} == prev_val) s = s ^ 7'b0000001;
            drive_item(d, s, $urandom_range(5, 16));
         end
      end

      // final long hold so the last capture settles, then drain
      d = 4'b0001;
      s = PAT[0];
      if ({d, s} == prev_val) s = PAT[1];
      drive_item(d, s, 20);
      repeat (15) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side companion to the team's BCD-to-7-segment decoders: monitors a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and recovers the BCD digit shown in each position.
- Sits between the display pins or a display model and the test/monitor logic; publishes a complete, atomically updated frame of NDIG digits.

Parameters:
- NDIG, 4, number of multiplexed digit positions (2..8).
- STABLE_CYC, 8, consecutive equal synchronized samples required before capture (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment lines {a,b,c,d,e,f,g}, bit 6 = a, active high.
- dig_in  in  NDIG  digit select, active high, expected one-hot; bit 0 = digit 0.
- bcd_out  out  4*NDIG  frame digits; digit i at [4i+3:4i].
- dig_err  out  NDIG  per-digit illegal-pattern flag for the current frame.
- frame_valid  out  1  one-cycle pulse: bcd_out/dig_err just updated.
- frame_lost  out  1  one-cycle pulse: partial frame discarded.
- sel_err  out  1  one-cycle pulse: stable window with dig_in not one-hot.

Behaviour:
- Reset: all synchronizers, counters and registers cleared; bcd_out = all 4'hF, dig_err = 0, frame_valid = frame_lost = sel_err = 0; FSM = ALIGN.
- Sync: {dig_in, seg_in} pass through 2 flops giving s_q; s_q is registered into p_q.
- Stability counter cnt (saturating at STABLE_CYC): if s_q != p_q, cnt <= 0; else cnt <= cnt+1 until saturated.
- Capture event fires exactly once per stable window, on the edge where s_q == p_q and cnt == STABLE_CYC-1.
  - If an input change is first sampled at edge k, capture occurs at edge k+STABLE_CYC+2.
  - A glitch shorter than the window produces no capture.
- Capture with dig_in not one-hot (zero or multi-hot): no digit written; sel_err pulses the following cycle.
- Decode table (seg to code):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4.
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - 0000000 = 4'hF (blank), err = 0.
  - Any other pattern = 4'hE, err = 1.
- Live registers: each one-hot capture writes code/err into live slot i and sets mask bit i. A repeat capture of the same digit overwrites the slot.
- FSM:
  - ALIGN: ignore captures except digit 0. A digit-0 capture writes slot 0, sets mask = 0...01, and moves to COLLECT.
  - COLLECT, non-zero digit: write slot i and set mask bit i. If this completes mask = all ones, on the same edge copy all live slots (including the new one) into bcd_out/dig_err, set frame_valid for the next cycle, clear mask, go to ALIGN.
  - COLLECT, digit 0 again with mask incomplete: pulse frame_lost, restart the frame (slot 0 written, mask = 0...01), stay in COLLECT.
- NDIG = 1: every valid capture completes a frame immediately.
- bcd_out/dig_err hold between frames. Reset mid-frame discards all partial state.
- Pulses never overlap except that sel_err is independent of the other two.

Decomposition:
- Package seg7_pkg: segment constants SEG_0..SEG_9, SEG_BLANK, CODE_BLANK = 4'hF, CODE_ERR = 4'hE, FSM state enum {ALIGN, COLLECT}.
- Sub-module seg7_to_bcd: purely combinational pattern-to-{code, err} lookup, shared with future monitors.

Test Plan:
- NDIG=4, STABLE_CYC=8; drive digits 0..3 = 1111110, 0110000, 1101101, 1111001, each held 20 cycles -> one frame_valid, bcd_out = 16'h3210, dig_err = 0.
- Hold a digit pattern exactly 10 edges after first sampling -> capture at edge k+10; a 7-cycle hold -> no capture, mask unchanged.
- Digit 2 shows 1010101 -> frame bcd_out[11:8] = 4'hE, dig_err = 4'b0100; digit 3 blank -> nibble 4'hF, err 0.
- dig_in = 4'b0110 held 20 cycles -> sel_err single pulse, no slot written, no frame_valid.
- Sequence dig 0, 1, 0, 1, 2, 3 -> frame_lost pulse at the second dig 0; frame_valid once, carrying the second-pass values.
- Assert rst_n low mid-COLLECT after digits 0-1 -> outputs return to 16'hFFFF/0 asynchronously; the next frame needs a fresh digit-0 alignment.
